// File: rtl/grid_pkg.sv
// Shared types and helpers for the LED-grid controller and its companions.
package grid_pkg;

  typedef enum logic [1:0] {
    S_NONE,
    S_ONE,
    S_HOLD,
    S_WIN
  } state_t;

  localparam int unsigned MAX_CARDS = 256;

  function automatic int unsigned idx_w(input int unsigned n);
    return $clog2(n);
  endfunction

  // Callers size-cast the result down to their own card count.
  function automatic logic [MAX_CARDS-1:0] onehot(input int unsigned idx, input int unsigned n);
    logic [MAX_CARDS-1:0] v;
    v = '0;
    if (idx < n && idx < MAX_CARDS) v = MAX_CARDS'(1) << idx;
    return v;
  endfunction

endpackage

// File: rtl/grid_led_ctrl_if.sv
// Game-FSM <-> LED-grid controller signal bundle.
interface grid_led_ctrl_if #(
  parameter int unsigned ROWS   = 6,
  parameter int unsigned COLS   = 6,
  parameter int unsigned FACE_W = 5
);
  localparam int unsigned N     = ROWS * COLS;
  localparam int unsigned IDX_W = grid_pkg::idx_w(N);

  logic [IDX_W-1:0]  cursor;
  logic              cursor_valid;
  logic              sel_strobe;
  logic [FACE_W-1:0] card_face;
  logic              new_game;
  logic [N-1:0]      leds;
  logic              busy;
  logic              match_pulse;
  logic              mismatch_pulse;
  logic [IDX_W-1:0]  pairs_found;
  logic              game_won;

  modport master (
    output cursor, cursor_valid, sel_strobe, card_face, new_game,
    input  leds, busy, match_pulse, mismatch_pulse, pairs_found, game_won
  );

  modport slave (
    input  cursor, cursor_valid, sel_strobe, card_face, new_game,
    output leds, busy, match_pulse, mismatch_pulse, pairs_found, game_won
  );

endinterface

// File: rtl/grid_blink_div.sv
// Free-running blink divider: phase toggles every DIV clocks, starts high.
module grid_blink_div #(
  parameter int unsigned DIV = 25_000_000
) (
  input  logic clock,
  input  logic reset,
  output logic phase
);
  localparam int unsigned CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] r_cnt;
  logic             r_phase;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt   <= '0;
      r_phase <= 1'b1;
    end else if (r_cnt == CNT_W'(DIV - 1)) begin
      r_cnt   <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign phase = r_phase;

endmodule

// File: rtl/grid_led_ctrl.sv
// Memory-card LED grid controller: open/matched card tracking, mismatch hold,
// cursor and win blinking, registered LED drive.
module grid_led_ctrl
  import grid_pkg::*;
#(
  parameter int unsigned ROWS        = 6,
  parameter int unsigned COLS        = 6,
  parameter int unsigned FACE_W      = 5,
  parameter int unsigned BLINK_DIV   = 25_000_000,
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input logic           clock,
  input logic           reset,
  grid_led_ctrl_if.slave bus
);
  localparam int unsigned N     = ROWS * COLS;
  localparam int unsigned IDX_W = idx_w(N);
  localparam int unsigned HALF  = N / 2;
  localparam int unsigned TMR_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  logic w_phase;

  grid_blink_div #(.DIV(BLINK_DIV)) u_blink (
    .clock (clock),
    .reset (reset),
    .phase (w_phase)
  );

  state_t            r_state;
  logic [N-1:0]      r_matched;
  logic [N-1:0]      r_leds;
  logic [IDX_W-1:0]  r_open1;
  logic [IDX_W-1:0]  r_open2;
  logic [IDX_W-1:0]  r_pairs;
  logic [FACE_W-1:0] r_face1;
  logic [TMR_W-1:0]  r_timer;
  logic              r_match;
  logic              r_mismatch;

  logic [N-1:0]     w_oh_cur;
  logic [N-1:0]     w_oh_o1;
  logic [N-1:0]     w_oh_o2;
  logic [N-1:0]     w_leds_nxt;
  logic [IDX_W-1:0] w_pairs_inc;
  logic             w_in_range;
  logic             w_valid_sel;

  always_comb begin
    w_oh_cur    = N'(onehot(32'(bus.cursor), N));
    w_oh_o1     = N'(onehot(32'(r_open1), N));
    w_oh_o2     = N'(onehot(32'(r_open2), N));
    w_pairs_inc = r_pairs + IDX_W'(1);
    // onehot() is zero for an out-of-range index, so it doubles as the range check
    w_in_range  = |w_oh_cur;
    w_valid_sel = bus.sel_strobe && w_in_range && !(|(r_matched & w_oh_cur)) &&
                  ((r_state == S_NONE) ||
                   ((r_state == S_ONE) && (bus.cursor != r_open1)));
  end

  always_comb begin
    w_leds_nxt = '0;
    if (r_state == S_WIN) begin
      w_leds_nxt = {N{w_phase}};
    end else begin
      w_leds_nxt = r_matched;
      if (r_state == S_ONE || r_state == S_HOLD) w_leds_nxt = w_leds_nxt | w_oh_o1;
      if (r_state == S_HOLD) w_leds_nxt = w_leds_nxt | w_oh_o2;
      if (bus.cursor_valid && w_phase) w_leds_nxt = w_leds_nxt | w_oh_cur;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || bus.new_game) begin
      r_state    <= S_NONE;
      r_matched  <= '0;
      r_leds     <= '0;
      r_open1    <= '0;
      r_open2    <= '0;
      r_pairs    <= '0;
      r_face1    <= '0;
      r_timer    <= '0;
      r_match    <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_match    <= 1'b0;
      r_mismatch <= 1'b0;
      r_leds     <= w_leds_nxt;
      case (r_state)
        S_NONE: begin
          if (w_valid_sel) begin
            r_open1 <= bus.cursor;
            r_face1 <= bus.card_face;
            r_state <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_valid_sel) begin
            if (bus.card_face == r_face1) begin
              r_matched <= r_matched | w_oh_cur | w_oh_o1;
              r_pairs   <= w_pairs_inc;
              r_match   <= 1'b1;
              r_state   <= (w_pairs_inc == IDX_W'(HALF)) ? S_WIN : S_NONE;
            end else begin
              r_open2    <= bus.cursor;
              r_timer    <= TMR_W'(HOLD_CYCLES - 1);
              r_mismatch <= 1'b1;
              r_state    <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (r_timer == '0) r_state <= S_NONE;
          else               r_timer <= r_timer - TMR_W'(1);
        end
        S_WIN: ;
        default: r_state <= S_NONE;
      endcase
    end
  end

  assign bus.leds           = r_leds;
  assign bus.busy           = (r_state == S_HOLD);
  assign bus.match_pulse    = r_match;
  assign bus.mismatch_pulse = r_mismatch;
  assign bus.pairs_found    = r_pairs;
  assign bus.game_won       = (r_state == S_WIN);

endmodule

// File: tb/tb_grid_led_ctrl.sv
// Directed + randomized check of grid_led_ctrl against a behavioural game model.
module tb_grid_led_ctrl;
  localparam int ROWS      = 1;
  localparam int COLS      = 5;
  localparam int FACE_W    = 5;
  localparam int BLINK_DIV = 4;
  localparam int HOLD      = 3;
  localparam int N         = ROWS * COLS;
  localparam int IDX_W     = $clog2(N);

  logic clock;
  logic reset;

  grid_led_ctrl_if #(.ROWS(ROWS), .COLS(COLS), .FACE_W(FACE_W)) bus ();

  grid_led_ctrl #(
    .ROWS(ROWS), .COLS(COLS), .FACE_W(FACE_W),
    .BLINK_DIV(BLINK_DIV), .HOLD_CYCLES(HOLD)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  // Game model: which cards are face-up, which are matched, how long a
  // mismatch stays shown, and the blink phase derived from elapsed cycles.
  bit           m_matched [N];
  int           m_open_cnt;      // 0 none, 1 one open, 2 mismatched pair shown
  int           m_open1, m_open2, m_face1;
  int           m_hold_left;
  bit           m_won;
  int           m_pairs;
  int           m_cycles;
  bit           m_match, m_mismatch;
  logic [N-1:0] m_leds;

  task automatic model_clear_game();
    foreach (m_matched[i]) m_matched[i] = 1'b0;
    m_open_cnt = 0; m_open1 = 0; m_open2 = 0; m_face1 = 0;
    m_hold_left = 0; m_won = 1'b0; m_pairs = 0;
    m_match = 1'b0; m_mismatch = 1'b0; m_leds = '0;
  endtask

  always @(posedge clock) begin
    bit           ph;
    bit           ok;
    int           cur;
    logic [N-1:0] nl;
    cur = int'(bus.cursor);
    ph  = ((m_cycles / BLINK_DIV) % 2) == 0;
    if (reset) begin
      model_clear_game();
      m_cycles = 0;
    end else begin
      nl = '0;
      if (m_won) begin
        nl = ph ? '1 : '0;
      end else begin
        for (int i = 0; i < N; i++) if (m_matched[i]) nl[i] = 1'b1;
        if (m_open_cnt >= 1) nl[m_open1] = 1'b1;
        if (m_open_cnt == 2) nl[m_open2] = 1'b1;
        if (bus.cursor_valid && ph && cur < N) nl[cur] = 1'b1;
      end
      m_match = 1'b0;
      m_mismatch = 1'b0;
      if (bus.new_game) begin
        model_clear_game();
        nl = '0;
      end else if (m_open_cnt == 2) begin
        m_hold_left--;
        if (m_hold_left == 0) m_open_cnt = 0;
      end else if (!m_won && bus.sel_strobe && cur < N) begin
        ok = !m_matched[cur] && !(m_open_cnt == 1 && cur == m_open1);
        if (ok && m_open_cnt == 0) begin
          m_open1 = cur; m_face1 = int'(bus.card_face); m_open_cnt = 1;
        end else if (ok && int'(bus.card_face) == m_face1) begin
          m_matched[cur] = 1'b1; m_matched[m_open1] = 1'b1;
          m_pairs++; m_match = 1'b1; m_open_cnt = 0;
          if (m_pairs == N / 2) m_won = 1'b1;
        end else if (ok) begin
          m_open2 = cur; m_open_cnt = 2; m_hold_left = HOLD; m_mismatch = 1'b1;
        end
      end
      m_leds = nl;
      m_cycles++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s @%0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic step(input int cur, input bit cv, input bit sel, input int face,
                      input bit ng, input bit rst);
    bus.cursor       = IDX_W'(cur);
    bus.cursor_valid = cv;
    bus.sel_strobe   = sel;
    bus.card_face    = FACE_W'(face);
    bus.new_game     = ng;
    reset            = rst;
    @(posedge clock);
    @(negedge clock);
    chk("leds",     32'(bus.leds),           32'(m_leds));
    chk("busy",     32'(bus.busy),           32'(m_open_cnt == 2));
    chk("match",    32'(bus.match_pulse),    32'(m_match));
    chk("mismatch", 32'(bus.mismatch_pulse), 32'(m_mismatch));
    chk("pairs",    32'(bus.pairs_found),    32'(m_pairs));
    chk("won",      32'(bus.game_won),       32'(m_won));
  endtask

  task automatic idle(input int n, input int cur, input bit cv);
    for (int i = 0; i < n; i++) step(cur, cv, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    bus.cursor = '0; bus.cursor_valid = 1'b0; bus.sel_strobe = 1'b0;
    bus.card_face = '0; bus.new_game = 1'b0;

    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    idle(10, 2, 1);                        // cursor blink on card 2

    step(0, 0, 1, 7, 0, 0);                // match {0,3}
    step(3, 0, 1, 7, 0, 0);
    idle(2, 0, 0);

    step(1, 0, 1, 2, 0, 0);                // mismatch {1,2}, strobe during hold
    step(2, 0, 1, 5, 0, 0);
    step(4, 0, 1, 5, 0, 0);
    idle(4, 0, 0);

    step(1, 0, 1, 2, 0, 0);                // illegal: reselect, matched, out of range
    step(1, 0, 1, 2, 0, 0);
    step(0, 0, 1, 7, 0, 0);
    step(6, 1, 1, 2, 0, 0);
    idle(6, 5, 1);

    step(2, 0, 1, 2, 0, 0);                // {1,2} completes floor(5/2) pairs -> win
    idle(10, 0, 0);
    step(4, 1, 1, 3, 0, 0);
    step(4, 1, 1, 3, 1, 0);                // new_game beats coincident strobe
    idle(3, 0, 0);

    step(0, 0, 1, 1, 0, 0);                // reset in the middle of a hold
    step(4, 0, 1, 2, 0, 0);
    idle(1, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    idle(1, 0, 0);
    step(3, 0, 1, 4, 0, 0);
    step(4, 0, 1, 4, 0, 0);
    idle(2, 0, 0);

    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 7), 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
           $urandom_range(0, 2), ($urandom_range(0, 80) == 0), ($urandom_range(0, 150) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
